// File: rtl/gcd_pkg.sv
// Shared types and helpers for the handshaked GCD engine.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gcd_state_e;

    typedef enum logic {
        GCD_SUB   = 1'b0,
        GCD_STEIN = 1'b1
    } gcd_mode_e;

    // Increment that sticks at max_v instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/gcd_engine_hs_if.sv
// Operand request and result response channels of the GCD engine.
interface gcd_engine_hs_if #(
    parameter int NBITS = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [NBITS-1:0] a_in;
    logic [NBITS-1:0] b_in;
    logic             mode_in;
    logic             out_valid;
    logic             out_ready;
    logic [NBITS-1:0] result;
    logic [CNT_W-1:0] cycles;
    logic             zero_flag;

    modport master (
        output in_valid, a_in, b_in, mode_in, out_ready,
        input  in_ready, out_valid, result, cycles, zero_flag
    );

    modport slave (
        input  in_valid, a_in, b_in, mode_in, out_ready,
        output in_ready, out_valid, result, cycles, zero_flag
    );
endinterface

// File: rtl/gcd_step.sv
// One GCD iteration, combinational: subtractive Euclid or binary Stein.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int NBITS = 32,
    parameter int KW    = 6
) (
    input  logic [NBITS-1:0] a_i,
    input  logic [NBITS-1:0] b_i,
    input  logic [KW-1:0]    k_i,
    input  gcd_mode_e        mode_i,
    output logic [NBITS-1:0] a_o,
    output logic [NBITS-1:0] b_o,
    output logic [KW-1:0]    k_o,
    output logic             term_o,
    output logic [NBITS-1:0] result_o
);
    logic [NBITS-1:0] diff_ab;
    logic [NBITS-1:0] diff_ba;

    // Each difference is only consumed on the branch where it cannot underflow.
    assign diff_ab = a_i - b_i;
    assign diff_ba = b_i - a_i;

    always_comb begin
        a_o      = a_i;
        b_o      = b_i;
        k_o      = k_i;
        term_o   = 1'b0;
        result_o = '0;
        if (mode_i == GCD_SUB) begin
            if (b_i == '0) begin
                term_o   = 1'b1;
                result_o = a_i;
            end else if (a_i < b_i) begin
                a_o = b_i;
                b_o = a_i;
            end else begin
                a_o = diff_ab;
            end
        end else begin
            if (a_i == '0 || b_i == '0) begin
                term_o   = 1'b1;
                result_o = (a_i | b_i) << k_i;
            end else if (!a_i[0] && !b_i[0]) begin
                a_o = a_i >> 1;
                b_o = b_i >> 1;
                k_o = k_i + KW'(1);
            end else if (!a_i[0]) begin
                a_o = a_i >> 1;
            end else if (!b_i[0]) begin
                b_o = b_i >> 1;
            end else if (a_i >= b_i) begin
                a_o = diff_ab >> 1;
            end else begin
                b_o = diff_ba >> 1;
            end
        end
    end
endmodule

// File: rtl/gcd_engine_hs.sv
// Handshaked GCD engine: IDLE accepts operands, RUN iterates one step per cycle, DONE holds the result.
module gcd_engine_hs
    import gcd_pkg::*;
#(
    parameter int NBITS = 32,
    parameter int CNT_W = 16
) (
    input logic             clk,
    input logic             reset_n,
    input logic             clear,
    gcd_engine_hs_if.slave  bus
);
    localparam int          KW      = $clog2(NBITS) + 1;
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    gcd_state_e       state_q, state_d;
    gcd_mode_e        mode_q, mode_d;
    logic [NBITS-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [KW-1:0]    k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cycles_q, cycles_d, cnt_inc;
    logic             zero_q, zero_d;

    logic [NBITS-1:0] step_a, step_b, step_res;
    logic [KW-1:0]    step_k;
    logic             step_term;

    gcd_step #(.NBITS(NBITS), .KW(KW)) u_step (
        .a_i      (a_q),
        .b_i      (b_q),
        .k_i      (k_q),
        .mode_i   (mode_q),
        .a_o      (step_a),
        .b_o      (step_b),
        .k_o      (step_k),
        .term_o   (step_term),
        .result_o (step_res)
    );

    assign cnt_inc = CNT_W'(sat_inc(32'(cnt_q), CNT_MAX));

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        a_d      = a_q;
        b_d      = b_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cycles_d = cycles_q;
        zero_d   = zero_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    mode_d  = gcd_mode_e'(bus.mode_in);
                    k_d     = '0;
                    cnt_d   = '0;
                    zero_d  = (bus.a_in == '0) && (bus.b_in == '0);
                    state_d = RUN;
                end
                RUN: begin
                    a_d   = step_a;
                    b_d   = step_b;
                    k_d   = step_k;
                    cnt_d = cnt_inc;
                    if (step_term) begin
                        result_d = step_res;
                        cycles_d = cnt_inc;
                        state_d  = DONE;
                    end
                end
                DONE: if (bus.out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mode_q   <= GCD_SUB;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            cycles_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cycles_q <= cycles_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.cycles    = cycles_q;
    assign bus.zero_flag = zero_q;
endmodule
